// File: rtl/jtag_vector_player.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jtag_vector_player : plays TMS/TDI step bytes from a RAM onto JTAG pins and
// writes captured TDO bits back. Option: JTAG_PLAYER_TDO_SYNC_EN. Rev 1.0
// ---------------------------------------------------------------------------
module jtag_vector_player #(
  parameter int ADDR_W = 12,
  parameter int W_MIN  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       tck_width,
  output logic [ADDR_W-1:0] vector_1_addr,
  input  logic [7:0]        vector_1_rd_data,
  output logic [ADDR_W-1:0] vector_2_addr,
  output logic              vector_2_we,
  output logic [7:0]        vector_2_wr_data,
  output logic              jtag_tck,
  output logic              jtag_tms,
  output logic              jtag_tdi,
  input  logic              jtag_tdo,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] LOW   = 3'd3;
  localparam logic [2:0] HIGH  = 3'd4;
  localparam logic [2:0] STORE = 3'd5;
  localparam logic [2:0] FIN   = 3'd6;

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;
  // A zero floor would make the phase counter underflow, so never go below 1.
  localparam logic [31:0] W_FLOOR = (W_MIN < 1) ? 32'd1 : 32'(W_MIN);

  logic [2:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic              step_capture;
  logic              step_last;
  logic [31:0]       cnt;
  logic [31:0]       w_eff;
  logic [31:0]       phase_load;
  logic              tdo_s;
  logic              last_step;
  logic              unused_bits;

  assign w_eff         = (tck_width < W_FLOOR) ? W_FLOOR : tck_width;
  assign phase_load    = w_eff - 32'd1;
  assign last_step     = step_last || (ptr == PTR_MAX);
  assign vector_1_addr = ptr;
  assign unused_bits   = ^vector_1_rd_data[6:3];

`ifdef JTAG_PLAYER_TDO_SYNC_EN
  logic [1:0] tdo_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tdo_sync <= 2'b00;
    end else begin
      tdo_sync <= {tdo_sync[0], jtag_tdo};
    end
  end

  assign tdo_s = tdo_sync[1];
`else
  assign tdo_s = jtag_tdo;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      ptr              <= '0;
      step_capture     <= 1'b0;
      step_last        <= 1'b0;
      cnt              <= 32'd0;
      vector_2_addr    <= '0;
      vector_2_we      <= 1'b0;
      vector_2_wr_data <= 8'd0;
      jtag_tck         <= 1'b0;
      jtag_tms         <= 1'b1;
      jtag_tdi         <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      done        <= 1'b0;
      vector_2_we <= 1'b0;
      // Abort wins over everything, including a start in the same cycle.
      if (abort) begin
        state    <= IDLE;
        busy     <= 1'b0;
        jtag_tck <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              ptr   <= '0;
              busy  <= 1'b1;
              state <= FETCH;
            end
          end
          FETCH: state <= LOAD;
          LOAD: begin
            step_capture <= vector_1_rd_data[2];
            step_last    <= vector_1_rd_data[7];
            jtag_tms     <= vector_1_rd_data[0];
            jtag_tdi     <= vector_1_rd_data[1];
            cnt          <= phase_load;
            state        <= LOW;
          end
          LOW: begin
            if (cnt == 32'd0) begin
              cnt      <= phase_load;
              jtag_tck <= 1'b1;
              state    <= HIGH;
            end else begin
              cnt <= cnt - 32'd1;
            end
          end
          HIGH: begin
            if (cnt == 32'd0) begin
              jtag_tck <= 1'b0;
              if (step_capture) begin
                vector_2_we      <= 1'b1;
                vector_2_addr    <= ptr;
                vector_2_wr_data <= {7'b0, tdo_s};
                state            <= STORE;
              end else if (last_step) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= FIN;
              end else begin
                ptr   <= ptr + 1'b1;
                state <= FETCH;
              end
            end else begin
              cnt <= cnt - 32'd1;
            end
          end
          STORE: begin
            if (last_step) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= FIN;
            end else begin
              ptr   <= ptr + 1'b1;
              state <= FETCH;
            end
          end
          FIN: begin
            jtag_tck <= 1'b0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtag_vector_player.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_jtag_vector_player : scoreboard bench for jtag_vector_player (ADDR_W=4).
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_jtag_vector_player;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset, start, abort, jtag_tdo;
  logic [31:0]   tck_width;
  logic [AW-1:0] vector_1_addr, vector_2_addr;
  logic [7:0]    vector_1_rd_data, vector_2_wr_data;
  logic          vector_2_we, jtag_tck, jtag_tms, jtag_tdi, busy, done;

  logic [7:0] mem1 [16];
  logic [7:0] mem2 [16];

  typedef struct {logic tms; logic tdi; int gap; int w;} step_t;
  typedef struct {logic [AW-1:0] addr; logic [7:0] data;} wr_t;
  step_t exp_steps[$];
  wr_t   exp_wr[$];

  int   errors = 0, checks = 0;
  int   we_cnt = 0, done_cnt = 0, rise_cnt = 0;
  int   low_run = 0, high_run = 0, cur_w = 0;
  bit   aborting = 1'b0;
  logic prev_tck = 1'b0;

  jtag_vector_player #(.ADDR_W(AW), .W_MIN(1)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .tck_width(tck_width),
    .vector_1_addr(vector_1_addr), .vector_1_rd_data(vector_1_rd_data),
    .vector_2_addr(vector_2_addr), .vector_2_we(vector_2_we),
    .vector_2_wr_data(vector_2_wr_data), .jtag_tck(jtag_tck), .jtag_tms(jtag_tms),
    .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo), .busy(busy), .done(done)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) vector_1_rd_data <= mem1[vector_1_addr];
  always @(posedge clk) if (vector_2_we) mem2[vector_2_addr] <= vector_2_wr_data;

  // Monitor: pops the scoreboard on every TCK rise and every capture write.
  initial forever begin
    step_t s;
    wr_t   e;
    @(negedge clk);
    if (reset) begin
      prev_tck = 1'b0; low_run = 0; high_run = 0;
    end else begin
      if (vector_2_we === 1'b1) begin
        we_cnt++;
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: got addr=%0d data=%02h, want no write", vector_2_addr, vector_2_wr_data);
        end else begin
          e = exp_wr.pop_front();
          if (vector_2_addr !== e.addr || vector_2_wr_data !== e.data) begin
            errors++;
            $display("FAIL wr_data: got addr=%0d data=%02h, want addr=%0d data=%02h",
                     vector_2_addr, vector_2_wr_data, e.addr, e.data);
          end
        end
      end
      if (done === 1'b1) done_cnt++;
      if (jtag_tck === 1'b1 && prev_tck === 1'b0) begin
        rise_cnt++;
        checks++;
        if (exp_steps.size() == 0) begin
          errors++;
          $display("FAIL tck_unexpected: got a TCK rise, want none");
        end else begin
          s = exp_steps.pop_front();
          cur_w = s.w;
          if (jtag_tms !== s.tms || jtag_tdi !== s.tdi || low_run != s.gap) begin
            errors++;
            $display("FAIL step: got tms=%b tdi=%b gap=%0d, want tms=%b tdi=%b gap=%0d",
                     jtag_tms, jtag_tdi, low_run, s.tms, s.tdi, s.gap);
          end
        end
        high_run = 0;
      end
      if (jtag_tck === 1'b1) begin
        high_run++;
      end else begin
        if (prev_tck === 1'b1 && !aborting) begin
          checks++;
          if (high_run != cur_w) begin
            errors++;
            $display("FAIL tck_high: got %0d cycles, want %0d", high_run, cur_w);
          end
        end
        if (prev_tck === 1'b1) low_run = 0;
        if (busy === 1'b1) low_run++;
        else low_run = 0;
      end
      prev_tck = jtag_tck;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic expect_prog(input int tw, input logic [15:0] tdo_pat, output int n);
    int    w;
    step_t s;
    wr_t   e;
    w = (tw < 1) ? 1 : tw;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      s.tms = mem1[i][0];
      s.tdi = mem1[i][1];
      s.w   = w;
      s.gap = w + 2 + ((i > 0 && mem1[i-1][2]) ? 1 : 0);
      exp_steps.push_back(s);
      if (mem1[i][2]) begin
        e.addr = AW'(i);
        e.data = {7'b0, tdo_pat[i]};
        exp_wr.push_back(e);
      end
      n++;
      if (mem1[i][7]) break;
    end
  endtask

  task automatic clear_mems();
    for (int i = 0; i < 16; i++) begin
      mem1[i] = 8'h00;
      mem2[i] = 8'hFF;
    end
    we_cnt = 0; done_cnt = 0; rise_cnt = 0;
  endtask

  task automatic start_pulse();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string name, input bit last_cap, input int budget);
    logic pt, pw;
    bit   got;
    pt = 1'b0; pw = 1'b0; got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        checks++;
        if ({pt, pw, busy} !== (last_cap ? 3'b010 : 3'b100)) begin
          errors++;
          $display("FAIL %s_done_timing: got prev_tck/prev_we/busy=%b, want %b", name,
                   {pt, pw, busy}, (last_cap ? 3'b010 : 3'b100));
        end
      end
      pt = jtag_tck; pw = vector_2_we;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_done_timeout: got no done in %0d cycles, want done", name, budget);
    end else begin
      @(negedge clk);
      if ({done, busy} !== 2'b00) begin
        errors++;
        $display("FAIL %s_done_width: got done/busy=%b, want 00", name, {done, busy});
      end
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_steps.size() != 0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: got %0d steps %0d writes left, want 0 0", name,
               exp_steps.size(), exp_wr.size());
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({jtag_tck, jtag_tms, jtag_tdi, busy, done, vector_2_we} !== 6'b010000) begin
      errors++;
      $display("FAIL %s_ctrl: got tck/tms/tdi/busy/done/we=%b, want 010000", name,
               {jtag_tck, jtag_tms, jtag_tdi, busy, done, vector_2_we});
    end
    checks++;
    if ({vector_1_addr, vector_2_addr, vector_2_wr_data} !== '0) begin
      errors++;
      $display("FAIL %s_data: got a1=%0h a2=%0h wd=%0h, want 0 0 0", name,
               vector_1_addr, vector_2_addr, vector_2_wr_data);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; jtag_tdo = 1'b0; tck_width = 32'd2;
    clear_mems();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("after_release");
  endtask

  task automatic test_basic();
    int n;
    clear_mems();
    mem1[0] = 8'h01; mem1[1] = 8'h02; mem1[2] = 8'h83;
    tck_width = 32'd2;
    expect_prog(2, 16'h0000, n);
    start_pulse();
    repeat (3) @(negedge clk);
    check_int("basic_busy", int'(busy), 1);
    start_pulse();
    wait_done("basic", 1'b0, 100);
    check_drained("basic");
    check_int("basic_we_cnt", we_cnt, 0);
    check_int("basic_done_cnt", done_cnt, 1);
    check_int("basic_rises", rise_cnt, n);
  endtask

  task automatic test_capture();
    int n;
    bit seen;
    clear_mems();
    mem1[0] = 8'h04; mem1[1] = 8'h84;
    tck_width = 32'd2; jtag_tdo = 1'b1;
    expect_prog(2, 16'h0001, n);
    start_pulse();
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (rise_cnt >= 1 && jtag_tck === 1'b0) seen = 1'b1;
    end
    jtag_tdo = 1'b0;
    wait_done("capture", 1'b1, 100);
    check_drained("capture");
    check_int("capture_mem0", int'(mem2[0]), 1);
    check_int("capture_mem1", int'(mem2[1]), 0);
    check_int("capture_we_cnt", we_cnt, 2);
  endtask

  task automatic test_min_width();
    int n;
    clear_mems();
    mem1[0] = 8'h03; mem1[1] = 8'h00; mem1[2] = 8'h82;
    tck_width = 32'd0;
    expect_prog(0, 16'h0000, n);
    start_pulse();
    wait_done("min_width", 1'b0, 100);
    check_drained("min_width");
    check_int("min_width_rises", rise_cnt, 3);
  endtask

  task automatic test_addr_wrap();
    int n;
    clear_mems();
    for (int i = 0; i < 16; i++) begin
      mem1[i] = {5'b0, (i % 4 == 3) ? 1'b1 : 1'b0, i[1], i[0]};
    end
    tck_width = 32'd1; jtag_tdo = 1'b1;
    expect_prog(1, 16'hFFFF, n);
    start_pulse();
    wait_done("wrap", 1'b1, 400);
    check_drained("wrap");
    check_int("wrap_steps", rise_cnt, 16);
    check_int("wrap_ptr", int'(vector_1_addr), 15);
    check_int("wrap_we_cnt", we_cnt, 4);
    repeat (10) @(negedge clk);
    check_int("wrap_no_restart", rise_cnt + int'(busy), 16);
  endtask

  task automatic test_abort();
    int n;
    bit seen;
    clear_mems();
    mem1[0] = 8'h01; mem1[1] = 8'h06; mem1[2] = 8'h83;
    tck_width = 32'd3; jtag_tdo = 1'b0;
    expect_prog(3, 16'h0000, n);
    void'(exp_steps.pop_back());
    exp_wr.delete();
    start_pulse();
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (rise_cnt == 2 && jtag_tck === 1'b1) seen = 1'b1;
    end
    aborting = 1'b1; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({busy, jtag_tck, vector_2_we, done} !== 4'b0000) begin
      errors++;
      $display("FAIL abort_next: got busy/tck/we/done=%b, want 0000",
               {busy, jtag_tck, vector_2_we, done});
    end
    repeat (8) @(negedge clk);
    aborting = 1'b0;
    check_int("abort_we_cnt", we_cnt, 0);
    check_int("abort_done_cnt", done_cnt, 0);
    check_int("abort_rises", rise_cnt, 2);
    check_drained("abort");
    expect_prog(3, 16'h0000, n);
    start_pulse();
    wait_done("replay", 1'b0, 200);
    check_drained("replay");
    check_int("replay_we_cnt", we_cnt, 1);
  endtask

  task automatic test_reset_mid();
    int n;
    bit seen;
    clear_mems();
    mem1[0] = 8'h04; mem1[1] = 8'h80;
    tck_width = 32'd2; jtag_tdo = 1'b1;
    expect_prog(2, 16'h0001, n);
    void'(exp_steps.pop_back());
    start_pulse();
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (vector_2_we === 1'b1) seen = 1'b1;
    end
    #2 reset = 1'b1;
    #1 check_reset_outputs("reset_mid");
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check_int("reset_mid_idle", rise_cnt * 4 + int'(busy) * 2 + done_cnt, 4);
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check_int("start_abort_busy", int'(busy), 0);
    repeat (6) @(negedge clk);
    check_int("start_abort_rises", rise_cnt, 1);
    check_int("reset_mid_we_cnt", we_cnt, 1);
    check_drained("reset_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_capture();
    test_min_width();
    test_addr_wrap();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
